blink: RTL and testbench

BLINK -- requirements
Module: blink

---
 rtl/blink_pkg.sv | 55 +++++
 rtl/clock_divider.sv | 33 +++
 rtl/blink.sv | 73 +++++++
 tb/tb_blink.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared step encoding, lamp patterns and 7-segment codes for blink
//
// Purpose: single source for the turn-signal step encoding, the lamp
//          patterns each step drives, and the active-low 7-segment codes.
// Ports:   none (package).
package blink_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } step_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_ONE = 3'b001;
  localparam logic [2:0] LAMP_TWO = 3'b011;
  localparam logic [2:0] LAMP_ALL = 3'b111;

  // Active-low segments, bit7 = decimal point (kept off).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic step_t next_step(input step_t s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      default: return S0;
    endcase
  endfunction

  function automatic logic [2:0] lamp_pattern(input step_t s);
    case (s)
      S0:      return LAMP_OFF;
      S1:      return LAMP_ONE;
      S2:      return LAMP_TWO;
      default: return LAMP_ALL;
    endcase
  endfunction

  function automatic logic [7:0] step_segments(input step_t s);
    case (s)
      S0:      return SEG_0;
      S1:      return SEG_1;
      S2:      return SEG_2;
      default: return SEG_3;
    endcase
  endfunction

endpackage

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - clock-enable tick generator for blink
//
// Purpose: counts 0..DIVIDE_BY-1 and asserts tick for one cycle while the
//          count sits at DIVIDE_BY-1; the output is an enable, not a clock.
// Ports:   clock - system clock (rising edge)
//          reset - synchronous, active-low; zeroes the counter
//          clear - synchronous restart of the counter to 0
//          tick  - one-cycle enable pulse every DIVIDE_BY cycles
module clock_divider #(
  parameter int unsigned DIVIDE_BY = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [23:0] LAST = 24'(DIVIDE_BY - 1);

  logic [23:0] count;

  // With DIVIDE_BY = 1 LAST is 0, so tick is high every cycle.
  assign tick = (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset || clear || tick) begin
      count <= 24'd0;
    end else begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/blink.sv
// rtl/blink.sv - turn-signal / hazard lamp animator with 7-segment step display
//
// Purpose: sequential turn animation (000,001,011,111) or hazard flash
//          (000/111) advanced by a divided tick; any change of hazards or
//          turnChange restarts the animation.
// Config:  BLINK_HEX_EN - when defined, hex shows the step digit or 'H';
//          otherwise hex is held blank (8'hFF).
// Ports:   clock      - system clock (rising edge)
//          reset      - synchronous, active-low
//          hazards    - 1 = hazard flash, 0 = sequential turn
//          turnChange - direction select; any level change restarts
//          leftLEDs   - left lamps, bit0 innermost
//          rightLEDs  - right lamps, bit0 innermost
//          hex        - active-low 7-segment code, bit7 = decimal point
module blink
  import blink_pkg::*;
#(
  parameter int unsigned DIVIDE_BY = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hazards,
  input  logic       turnChange,
  output logic [2:0] leftLEDs,
  output logic [2:0] rightLEDs,
  output logic [7:0] hex
);

  step_t step;
  logic  phase;
  logic  turn_q;
  logic  hazards_q;
  logic  tick;
  logic  restart;

  assign restart = (turnChange != turn_q) || (hazards != hazards_q);

  clock_divider #(.DIVIDE_BY(DIVIDE_BY)) u_divider (
    .clock (clock),
    .reset (reset),
    .clear (restart),
    .tick  (tick)
  );

  // Restart is tested before tick, so a coincident tick is dropped.
  always_ff @(posedge clock) begin
    turn_q    <= turnChange;
    hazards_q <= hazards;
    if (!reset || restart) begin
      step  <= S0;
      phase <= 1'b0;
    end else if (tick) begin
      if (hazards) begin
        phase <= ~phase;
      end else begin
        step <= next_step(step);
      end
    end
  end

  logic [2:0] lamps;

  assign lamps     = hazards ? (phase ? LAMP_ALL : LAMP_OFF) : lamp_pattern(step);
  assign leftLEDs  = lamps;
  assign rightLEDs = lamps;

`ifdef BLINK_HEX_EN
  assign hex = hazards ? SEG_H : step_segments(step);
`else
  assign hex = SEG_BLANK;
`endif

endmodule

// File: tb/tb_blink.sv
// tb/tb_blink.sv - directed self-checking bench for blink (DIVIDE_BY 1 and 4)
module tb_blink;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hazards = 1'b0;
  logic       turnChange = 1'b1;
  logic [2:0] left1, right1, left4, right4;
  logic [7:0] hex1, hex4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  blink #(.DIVIDE_BY(1)) dut1 (
    .clock(clock), .reset(reset), .hazards(hazards), .turnChange(turnChange),
    .leftLEDs(left1), .rightLEDs(right1), .hex(hex1)
  );

  blink #(.DIVIDE_BY(4)) dut4 (
    .clock(clock), .reset(reset), .hazards(hazards), .turnChange(turnChange),
    .leftLEDs(left4), .rightLEDs(right4), .hex(hex4)
  );

  // Hand table of display codes for each lamp pattern.
  function automatic logic [7:0] exp_hex(input logic [2:0] leds, input logic haz);
`ifdef BLINK_HEX_EN
    if (haz) return 8'h89;
    case (leds)
      3'b000:  return 8'hC0;
      3'b001:  return 8'hF9;
      3'b011:  return 8'hA4;
      default: return 8'hB0;
    endcase
`else
    return (leds == 3'b111 && haz) ? 8'hFF : 8'hFF;
`endif
  endfunction

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic haz, input logic tc);
    hazards = haz;
    turnChange = tc;
    reset = 1'b0;
    edge_step();
    edge_step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b1);
    vectors++;
    if ({left1, right1, hex1} !== {3'b000, 3'b000, exp_hex(3'b000, 1'b0)}) begin
      miscompares++;
      $display("FAIL reset_d1: got %b %b %h want 000 000 %h", left1, right1, hex1, exp_hex(3'b000, 1'b0));
    end
    vectors++;
    if ({left4, right4, hex4} !== {3'b000, 3'b000, exp_hex(3'b000, 1'b0)}) begin
      miscompares++;
      $display("FAIL reset_d4: got %b %b %h want 000 000 %h", left4, right4, hex4, exp_hex(3'b000, 1'b0));
    end
    reset = 1'b0;
    hazards = 1'b1;
    edge_step();
    vectors++;
    if ({left1, right1, hex1} !== {3'b000, 3'b000, exp_hex(3'b000, 1'b1)}) begin
      miscompares++;
      $display("FAIL reset_hazard: got %b %b %h want 000 000 %h", left1, right1, hex1, exp_hex(3'b000, 1'b1));
    end
  endtask

  task automatic test_turn_d1();
    logic [2:0] exp_seq [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      edge_step();
      vectors++;
      if ({left1, right1, hex1} !== {exp_seq[i], exp_seq[i], exp_hex(exp_seq[i], 1'b0)}) begin
        miscompares++;
        $display("FAIL turn_d1[%0d]: got %b %b %h want %b %b %h", i, left1, right1, hex1,
                 exp_seq[i], exp_seq[i], exp_hex(exp_seq[i], 1'b0));
      end
    end
  endtask

  task automatic test_turn_d4();
    logic [2:0] pat [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    do_reset(1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      edge_step();
      vectors++;
      if ({left4, right4, hex4} !== {pat[k/4], pat[k/4], exp_hex(pat[k/4], 1'b0)}) begin
        miscompares++;
        $display("FAIL turn_d4[%0d]: got %b %b %h want %b %b %h", k, left4, right4, hex4,
                 pat[k/4], pat[k/4], exp_hex(pat[k/4], 1'b0));
      end
    end
  endtask

  task automatic test_hazard();
    logic [2:0] exp_seq [4] = '{3'b111, 3'b000, 3'b111, 3'b000};
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      edge_step();
      vectors++;
      if ({left1, right1, hex1} !== {exp_seq[i], exp_seq[i], exp_hex(exp_seq[i], 1'b1)}) begin
        miscompares++;
        $display("FAIL hazard_d1[%0d]: got %b %b %h want %b %b %h", i, left1, right1, hex1,
                 exp_seq[i], exp_seq[i], exp_hex(exp_seq[i], 1'b1));
      end
    end
    // Switching into hazard mode restarts at phase 0, so the first edge stays dark.
    do_reset(1'b0, 1'b1);
    edge_step();
    edge_step();
    hazards = 1'b1;
    edge_step();
    vectors++;
    if ({left1, right1, hex1} !== {3'b000, 3'b000, exp_hex(3'b000, 1'b1)}) begin
      miscompares++;
      $display("FAIL hazard_restart: got %b %b %h want 000 000 %h", left1, right1, hex1, exp_hex(3'b000, 1'b1));
    end
    edge_step();
    vectors++;
    if ({left1, right1} !== {3'b111, 3'b111}) begin
      miscompares++;
      $display("FAIL hazard_after_restart: got %b %b want 111 111", left1, right1);
    end
  endtask

  task automatic test_restart();
    logic [2:0] after [4] = '{3'b000, 3'b000, 3'b000, 3'b001};
    // ncyc 8: at S2 with the counter at 0; ncyc 11: at S2 with a tick pending.
    int         ncyc [2] = '{8, 11};
    for (int r = 0; r < 2; r++) begin
      do_reset(1'b0, r[0]);
      repeat (ncyc[r]) edge_step();
      vectors++;
      if (left4 !== 3'b011) begin
        miscompares++;
        $display("FAIL restart_pre[%0d]: got %b want 011", r, left4);
      end
      turnChange = ~turnChange;
      for (int i = 0; i < 5; i++) begin
        edge_step();
        vectors++;
        if ({left4, right4, hex4} !== {(i == 0 ? 3'b000 : after[i-1]), (i == 0 ? 3'b000 : after[i-1]),
                                       exp_hex(i == 0 ? 3'b000 : after[i-1], 1'b0)}) begin
          miscompares++;
          $display("FAIL restart[%0d][%0d]: got %b %b %h", r, i, left4, right4, hex4);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b1);
    repeat (3) edge_step();
    vectors++;
    if (left1 !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got %b want 111", left1);
    end
    reset = 1'b0;
    edge_step();
    vectors++;
    if ({left1, right1, hex1} !== {3'b000, 3'b000, exp_hex(3'b000, 1'b0)}) begin
      miscompares++;
      $display("FAIL reset_mid: got %b %b %h want 000 000 %h", left1, right1, hex1, exp_hex(3'b000, 1'b0));
    end
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_step();
      vectors++;
      if (left4 !== ((k == 4) ? 3'b001 : 3'b000)) begin
        miscompares++;
        $display("FAIL reset_release_d4[%0d]: got %b want %b", k, left4, (k == 4) ? 3'b001 : 3'b000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_turn_d1();
    test_turn_d4();
    test_hazard();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
